// File: rtl/io_map_pkg.sv
// Address map and request types shared by the MMIO controller.
package io_map_pkg;

  // Upper two address bits that select the I/O region.
  localparam logic [1:0] IO_REGION_TAG = 2'b10;

  // Register offsets within the I/O region (addr[7:0]).
  localparam logic [7:0] UART_STATUS = 8'h00;
  localparam logic [7:0] UART_RX     = 8'h04;
  localparam logic [7:0] UART_TX     = 8'h08;
  localparam logic [7:0] CYC_CTR     = 8'h10;
  localparam logic [7:0] INSTR_CTR   = 8'h14;
  localparam logic [7:0] CTR_RST     = 8'h18;

  // Bit positions inside the UART status word.
  localparam int TX_READY_BIT = 0;
  localparam int RX_VALID_BIT = 1;

  // An effective (hit and not stalled) request, already decoded.
  typedef struct packed {
    logic       rd;
    logic       wr;
    logic [7:0] off;
  } io_req_t;

endpackage

// File: rtl/io_perf_counters.sv
// Free-running cycle counter and retired-instruction counter with a shared clear.
module io_perf_counters #(
  parameter int CTR_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clear,
  input  logic                 retire_en,
  output logic [CTR_WIDTH-1:0] cycle_ctr,
  output logic [CTR_WIDTH-1:0] instr_ctr
);

  logic [CTR_WIDTH-1:0] cycle_ctr_d, cycle_ctr_q;
  logic [CTR_WIDTH-1:0] instr_ctr_d, instr_ctr_q;

  // Next-count logic: clear wins over this cycle's increment; wrap is natural.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    cycle_ctr_d = cycle_ctr_q + CTR_WIDTH'(1);
    instr_ctr_d = instr_ctr_q;
    if (retire_en) instr_ctr_d = instr_ctr_q + CTR_WIDTH'(1);
    if (clear) begin
      cycle_ctr_d = '0;
      instr_ctr_d = '0;
    end
  end

  // Counter state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignment so all flops update from pre-edge values.
    if (!rst_n) begin
      cycle_ctr_q <= '0;
      instr_ctr_q <= '0;
    end else begin
      cycle_ctr_q <= cycle_ctr_d;
      instr_ctr_q <= instr_ctr_d;
    end
  end

  assign cycle_ctr = cycle_ctr_q;
  assign instr_ctr = instr_ctr_q;

endmodule

// File: rtl/io_mmio_ctrl.sv
// MMIO controller: decodes I/O loads/stores, runs the UART handshakes with a
// one-entry TX buffer, and returns registered read data one cycle later.
module io_mmio_ctrl
  import io_map_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter int CTR_WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             stall,
  input  logic [WIDTH-1:0] addr,
  input  logic             rd_en,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wdata,
  input  logic             instr_retire,
  input  logic [7:0]       uart_rx_data_out,
  input  logic             uart_rx_data_out_valid,
  output logic             uart_rx_data_out_ready,
  output logic [7:0]       uart_tx_data_in,
  output logic             uart_tx_data_in_valid,
  input  logic             uart_tx_data_in_ready,
  output logic [WIDTH-1:0] rdata
);

  io_req_t              req;
  logic                 tx_accept;
  logic                 ctr_clear;
  logic [WIDTH-1:0]     rd_val;
  logic [CTR_WIDTH-1:0] cycle_ctr, instr_ctr;

  logic                 tx_full_d, tx_full_q;
  logic [7:0]           tx_byte_d, tx_byte_q;
  logic [WIDTH-1:0]     rdata_d, rdata_q;

  // Address bits outside the tag and offset, and the upper store data, are don't-care.
  logic unused_bits;
  assign unused_bits = ^{addr[WIDTH-3:8], wdata[WIDTH-1:8]};

  // Request decode: only a hit in the I/O region while not stalled has side effects.
  always_comb begin
    req.off = addr[7:0];
    req.rd  = rd_en && (addr[WIDTH-1:WIDTH-2] == IO_REGION_TAG) && !stall;
    req.wr  = wr_en && (addr[WIDTH-1:WIDTH-2] == IO_REGION_TAG) && !stall;
  end

  assign uart_rx_data_out_ready = req.rd && (req.off == UART_RX);
  assign ctr_clear              = req.wr && (req.off == CTR_RST);

  // TX holding buffer: a write refills it when empty or draining; otherwise it is dropped.
  always_comb begin
    tx_full_d = tx_full_q;
    tx_byte_d = tx_byte_q;
    tx_accept = req.wr && (req.off == UART_TX) && (!tx_full_q || uart_tx_data_in_ready);
    if (tx_accept) begin
      tx_full_d = 1'b1;
      tx_byte_d = wdata[7:0];
    end else if (tx_full_q && uart_tx_data_in_ready) begin
      tx_full_d = 1'b0;
    end
  end

  // Read mux: unmapped and write-only offsets read as zero.
  always_comb begin
    rd_val = '0;
    unique case (req.off)
      UART_STATUS: begin
        rd_val[TX_READY_BIT] = !tx_full_q;
        rd_val[RX_VALID_BIT] = uart_rx_data_out_valid;
      end
      UART_RX:   rd_val[7:0] = uart_rx_data_out;
      CYC_CTR:   rd_val      = WIDTH'(cycle_ctr);
      INSTR_CTR: rd_val      = WIDTH'(instr_ctr);
      default:   rd_val      = '0;
    endcase
    rdata_d = req.rd ? rd_val : rdata_q;
  end

  // Buffer and read-data registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_full_q <= 1'b0;
      tx_byte_q <= '0;
      rdata_q   <= '0;
    end else begin
      tx_full_q <= tx_full_d;
      tx_byte_q <= tx_byte_d;
      rdata_q   <= rdata_d;
    end
  end

  io_perf_counters #(.CTR_WIDTH(CTR_WIDTH)) u_ctrs (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (ctr_clear),
    .retire_en (instr_retire && !stall),
    .cycle_ctr (cycle_ctr),
    .instr_ctr (instr_ctr)
  );

  assign uart_tx_data_in       = tx_byte_q;
  assign uart_tx_data_in_valid = tx_full_q;
  assign rdata                 = rdata_q;

endmodule

// File: tb/tb_io_mmio_ctrl.sv
// Self-checking bench: directed scenarios with literal expectations, then
// randomized traffic compared every cycle against a register-level model.
module tb_io_mmio_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stall = 1'b0;
  logic [31:0] addr = '0;
  logic        rd_en = 1'b0;
  logic        wr_en = 1'b0;
  logic [31:0] wdata = '0;
  logic        instr_retire = 1'b0;
  logic [7:0]  rx_data = '0;
  logic        rx_valid = 1'b0;
  logic        rx_ready;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready = 1'b0;
  logic [31:0] rdata;

  // Narrow-counter instance used only to observe wrap-around quickly.
  logic        w_rst_n = 1'b0;
  logic        w_rx_ready;
  logic [7:0]  w_tx_data;
  logic        w_tx_valid;
  logic [31:0] w_rdata;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  io_mmio_ctrl #(.WIDTH(32), .CTR_WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .addr(addr), .rd_en(rd_en),
    .wr_en(wr_en), .wdata(wdata), .instr_retire(instr_retire),
    .uart_rx_data_out(rx_data), .uart_rx_data_out_valid(rx_valid),
    .uart_rx_data_out_ready(rx_ready), .uart_tx_data_in(tx_data),
    .uart_tx_data_in_valid(tx_valid), .uart_tx_data_in_ready(tx_ready),
    .rdata(rdata)
  );

  io_mmio_ctrl #(.WIDTH(32), .CTR_WIDTH(4)) dut_w (
    .clk(clk), .rst_n(w_rst_n), .stall(1'b0), .addr(32'h8000_0010), .rd_en(1'b1),
    .wr_en(1'b0), .wdata(32'h0), .instr_retire(1'b0),
    .uart_rx_data_out(8'h00), .uart_rx_data_out_valid(1'b0),
    .uart_rx_data_out_ready(w_rx_ready), .uart_tx_data_in(w_tx_data),
    .uart_tx_data_in_valid(w_tx_valid), .uart_tx_data_in_ready(1'b0),
    .rdata(w_rdata)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [31:0] m_cyc = '0, m_ins = '0, m_rdata = '0;
  logic        m_full = 1'b0;
  logic [7:0]  m_byte = '0;
  logic        m_eff;
  logic        m_accept;

  function automatic logic [31:0] reg_value(input logic [7:0] off);
    case (off)
      8'h00:   return {30'b0, rx_valid, !m_full};
      8'h04:   return {24'b0, rx_data};
      8'h10:   return m_cyc;
      8'h14:   return m_ins;
      default: return 32'h0;
    endcase
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_cyc = '0; m_ins = '0; m_rdata = '0; m_full = 1'b0; m_byte = '0;
    end else begin
      m_eff = (addr[31:30] == 2'b10) && !stall;
      if (m_eff && rd_en) m_rdata = reg_value(addr[7:0]);
      m_accept = m_eff && wr_en && addr[7:0] == 8'h08 && (!m_full || tx_ready);
      if (m_accept) begin
        m_full = 1'b1;
        m_byte = wdata[7:0];
      end else if (m_full && tx_ready) begin
        m_full = 1'b0;
      end
      if (m_eff && wr_en && addr[7:0] == 8'h18) begin
        m_cyc = '0;
        m_ins = '0;
      end else begin
        m_cyc = m_cyc + 1;
        if (instr_retire && !stall) m_ins = m_ins + 1;
      end
    end
  end

  // Compare process: every falling edge, all outputs against the model.
  always @(negedge clk) begin
    check("rdata", rdata, m_rdata);
    check("tx_valid", {31'b0, tx_valid}, {31'b0, m_full});
    check("tx_data", {24'b0, tx_data}, {24'b0, m_byte});
    check("rx_ready", {31'b0, rx_ready},
          {31'b0, rd_en && !stall && addr[31:30] == 2'b10 && addr[7:0] == 8'h04});
  end

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    rd_en = 1'b0; wr_en = 1'b0; stall = 1'b0; instr_retire = 1'b0;
  endtask

  task automatic do_rd(input logic [7:0] off);
    addr = {2'b10, 22'h0, off}; rd_en = 1'b1; wr_en = 1'b0;
  endtask

  task automatic do_wr(input logic [7:0] off, input logic [31:0] d);
    addr = {2'b10, 22'h0, off}; wr_en = 1'b1; rd_en = 1'b0; wdata = d;
  endtask

  // Wrap check on the 4-bit counter instance: read of 0x10 held every cycle.
  initial begin
    repeat (2) @(posedge clk);
    #1 w_rst_n = 1'b1;
    for (int n = 1; n <= 17; n++) begin
      step();
      if (n == 16) check("wrap_all_ones", w_rdata, 32'd15);
      if (n == 17) check("wrap_to_zero", w_rdata, 32'd0);
    end
  end

  logic [7:0] offs [9] = '{8'h00, 8'h04, 8'h08, 8'h10, 8'h14, 8'h18, 8'h0C, 8'h1C, 8'hFF};

  initial begin
    // Reset state.
    repeat (2) step();
    check("reset_rdata", rdata, 32'h0);
    check("reset_tx_valid", {31'b0, tx_valid}, 32'h0);
    rst_n = 1'b1;

    // Idle 10 cycles then read counters.
    repeat (10) step();
    do_rd(8'h10); step();
    check("cycle_after_10", rdata, 32'd10);
    do_rd(8'h14); step();
    check("instr_idle", rdata, 32'd0);

    // RX status and data.
    rx_valid = 1'b1; rx_data = 8'h5A;
    do_rd(8'h00); step();
    check("status_rx_tx", rdata, 32'h3);
    do_rd(8'h04); #1;
    check("rx_ready_pulse", {31'b0, rx_ready}, 32'h1);
    step();
    check("rx_byte", rdata, 32'h5A);
    idle(); #1;
    check("rx_ready_drop", {31'b0, rx_ready}, 32'h0);
    rx_valid = 1'b0;

    // TX buffer fills, rejects a second byte, then drains.
    tx_ready = 1'b0;
    do_wr(8'h08, 32'h41); step();
    check("tx_valid_full", {31'b0, tx_valid}, 32'h1);
    check("tx_byte_41", {24'b0, tx_data}, 32'h41);
    do_rd(8'h00); step();
    check("status_full", rdata, 32'h0);
    do_wr(8'h08, 32'h42); step();
    check("tx_drop", {24'b0, tx_data}, 32'h41);
    idle(); tx_ready = 1'b1; step();
    check("tx_drained", {31'b0, tx_valid}, 32'h0);
    tx_ready = 1'b0;
    do_rd(8'h00); step();
    check("status_empty", rdata, 32'h1);

    // Drain and refill in the same cycle.
    do_wr(8'h08, 32'h41); step();
    tx_ready = 1'b1; do_wr(8'h08, 32'h43); step();
    check("refill_valid", {31'b0, tx_valid}, 32'h1);
    check("refill_byte", {24'b0, tx_data}, 32'h43);
    idle(); tx_ready = 1'b0;

    // Retire counting with stalls, then counter reset.
    do_wr(8'h18, 32'hDEAD); step();
    idle();
    for (int i = 0; i < 5; i++) begin
      instr_retire = 1'b1; stall = (i >= 3); step();
    end
    idle();
    do_rd(8'h14); step();
    check("instr_3", rdata, 32'd3);
    do_wr(8'h18, 32'h0); step();
    do_rd(8'h10); step();
    check("cycle_cleared", rdata, 32'd0);
    do_rd(8'h14); step();
    check("instr_cleared", rdata, 32'd0);

    // Stall blocks reads and the RX handshake.
    rx_valid = 1'b1; stall = 1'b1;
    do_rd(8'h04); #1;
    check("stall_no_rx_ready", {31'b0, rx_ready}, 32'h0);
    step();
    do_rd(8'h10); step(); step();
    check("stall_hold_rdata", rdata, 32'd0);
    idle();

    // Asynchronous reset mid-cycle with a full TX buffer.
    do_wr(8'h08, 32'h55); step();
    do_rd(8'h00); step();
    check("status_before_rst", rdata, 32'h2);
    check("tx_full_before_rst", {31'b0, tx_valid}, 32'h1);
    idle(); #2;
    rst_n = 1'b0; #1;
    check("async_tx_valid", {31'b0, tx_valid}, 32'h0);
    check("async_rdata", rdata, 32'h0);
    step();
    rst_n = 1'b1;
    rx_valid = 1'b0;

    // Randomized traffic checked against the model every cycle.
    for (int i = 0; i < 3000; i++) begin
      addr[31:30]  = ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'b10;
      addr[29:8]   = 22'($urandom);
      addr[7:0]    = offs[$urandom_range(0, 8)];
      rd_en        = $urandom_range(0, 1) == 1;
      wr_en        = ($urandom_range(0, 2) == 0) && !(addr[7:0] == 8'h18 && $urandom_range(0, 7) != 0);
      wdata        = $urandom;
      stall        = $urandom_range(0, 4) == 0;
      instr_retire = $urandom_range(0, 1) == 1;
      rx_valid     = $urandom_range(0, 1) == 1;
      rx_data      = 8'($urandom);
      tx_ready     = $urandom_range(0, 2) == 0;
      step();
    end
    idle();
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
